instr_executor: RTL and testbench
=================================

INSTR_EXECUTOR -- requirements
Module: instr_executor

Interface
REQ-001 The block SHALL expose exactly the following ports, one per line: name, direction, width, meaning.
  clk  input  1  single clock, all state on rising edge
  reset_n  input  1  asynchronous, active-low reset
  start  input  1  launch batch; sampled only in IDLE
  first_addr  input  address_t (5)  register slot of first instruction
  count  input  6  instructions in batch, 0..32
  read_pointer  output  address_t (5)  slot being fetched
  instruction_word  input  instruction_t  register contents at read_pointer; result field ignored
  res_we  output  1  result write strobe, one cycle per instruction
  res_addr  output  address_t (5)  slot the result belongs to
  res_data  output  operand_d_t (64, signed)  computed result
  busy  output  1  batch in progress
  done  output  1  one-cycle pulse at batch end
  err  output  1  sticky: some instruction in the batch faulted
REQ-002 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The design SHALL have no parameters; widths SHALL come from opcode_t, operand_t, operand_d_t and address_t.

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, EXEC, WRITE and FINISH.
REQ-005 In IDLE with start=1: latch first_addr into read_pointer and count into the remaining counter, clear err; go to FINISH if count=0, else go to FETCH.
REQ-006 In IDLE with start=0, the FSM SHALL stay in IDLE; start in any other state SHALL be ignored.
REQ-007 In FETCH, the block SHALL capture opc, op_a and op_b from instruction_word, then go to EXEC.
REQ-008 EXEC SHALL last 1 cycle for every opcode except POV, which SHALL last exactly 32 cycles; EXEC then goes to WRITE.
REQ-009 ZERO SHALL give 0, PASSA op_a, and PASSB op_b, each sign-extended to 64 bits.
REQ-010 ADD and SUB SHALL sign-extend both operands to 64 bits before the operation, so the result never overflows.
REQ-011 MULT SHALL produce the full 64-bit signed product.
REQ-012 DIV and MOD SHALL follow SystemVerilog signed semantics: truncate toward zero; remainder takes the sign of op_a.
REQ-013 DIV or MOD with op_b=0 SHALL give result 0 and set err.
REQ-014 POV SHALL compute op_a**op_b by square-and-multiply: one exponent bit per EXEC cycle, LSB first, all 32 bits.
REQ-015 POV intermediate values SHALL wrap modulo 2^64, and the result SHALL be the low 64 bits.
REQ-016 POV with op_b<0 SHALL give 0 without setting err; 0**0 SHALL give 1.
REQ-017 Opcode encodings 9..15 SHALL give result 0 and set err.
REQ-018 In WRITE, for exactly one cycle: res_we=1, res_addr=read_pointer, res_data=result.
REQ-019 Also in WRITE: decrement the remaining counter and increment read_pointer modulo 32 (31 wraps to 0).
REQ-020 WRITE SHALL go to FETCH if the remaining count is still nonzero, else to FINISH.
REQ-021 FINISH SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 Per-instruction latency SHALL be 3 cycles (34 for POV).
REQ-024 A batch of N non-POV instructions SHALL run from the start edge to done in 3N+1 cycles.
REQ-025 When count=32 the batch SHALL wrap the address and process every slot exactly once.
REQ-026 res_addr and res_data SHALL hold their last values when res_we=0.
REQ-027 err SHALL stay asserted until the next accepted start or reset.

Reset
REQ-028 On reset_n=0, asynchronously: FSM to IDLE; read_pointer, res_addr, res_data and the remaining counter to 0; res_we, busy, done and err to 0.
REQ-029 Reset asserted mid-batch SHALL abort the batch with no further res_we and no done pulse.
REQ-030 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-031 Bench SHALL cover: start, first_addr=0, count=1, slot0={ADD,5,-7} -> res_we at cycle 3, res_addr=0, res_data=-2, done at cycle 4, err=0.
REQ-032 Bench SHALL cover: count=2, first_addr=31, slot31={MULT,-65536,65536}, slot0={DIV,7,0} -> writes (31,-4294967296) then (0,0); err=1; done after 7 cycles.
REQ-033 Bench SHALL cover: {POV,3,5} -> res_data=243 after 34 cycles; {POV,2,-1} -> 0; {POV,0,0} -> 1.
REQ-034 Bench SHALL cover: {MOD,-7,2} -> -1; opcode 4'hF -> res_data 0, err=1; count=0 -> done 1 cycle after start, no res_we.
REQ-035 Bench SHALL cover: start pulsed while busy -> ignored; reset_n low during EXEC -> busy=0 and res_we=0 immediately, no done.
REQ-036 Bench SHALL cover: count=32 from first_addr=5 -> 32 writes, addresses 5..31 then 0..4, busy throughout, single done.

Source files
------------

// File: rtl/instr_executor.sv
// Batch executor: fetches count instructions from consecutive slots, one result write each.
// Latency 3 cycles per instruction (34 for POV); no backpressure, start is ignored while busy.
package instr_pkg;
   typedef logic [3:0]         opcode_t;
   typedef logic signed [31:0] operand_t;
   typedef logic signed [63:0] operand_d_t;
   typedef logic [4:0]         address_t;

   typedef struct packed {
      opcode_t    opc;
      operand_t   op_a;
      operand_t   op_b;
      operand_d_t result;
   } instruction_t;

   localparam opcode_t OPC_ZERO  = 4'd0;
   localparam opcode_t OPC_PASSA = 4'd1;
   localparam opcode_t OPC_PASSB = 4'd2;
   localparam opcode_t OPC_ADD   = 4'd3;
   localparam opcode_t OPC_SUB   = 4'd4;
   localparam opcode_t OPC_MULT  = 4'd5;
   localparam opcode_t OPC_DIV   = 4'd6;
   localparam opcode_t OPC_MOD   = 4'd7;
   localparam opcode_t OPC_POV   = 4'd8;
endpackage

module instr_executor
   import instr_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  address_t     first_addr,
   input  logic [5:0]   count,
   output address_t     read_pointer,
   input  instruction_t instruction_word,
   output logic         res_we,
   output address_t     res_addr,
   output operand_d_t   res_data,
   output logic         busy,
   output logic         done,
   output logic         err
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WRITE, S_FINISH} state_t;

   state_t     state_q, state_d;
   address_t   rp_q, rp_d;
   logic [5:0] rem_q, rem_d;
   opcode_t    opc_q, opc_d;
   operand_t   op_a_q, op_a_d;
   operand_t   op_b_q, op_b_d;
   logic [4:0] cyc_q, cyc_d;
   operand_d_t acc_q, acc_d;
   operand_d_t base_q, base_d;
   address_t   res_addr_q, res_addr_d;
   operand_d_t res_data_q, res_data_d;
   logic       err_q, err_d;

   operand_d_t a_ext, b_ext, acc_step, alu_res;
   logic       alu_err, exec_last;
   logic       unused_result;

   assign unused_result = ^instruction_word.result;
   assign a_ext         = {{32{op_a_q[31]}}, op_a_q};
   assign b_ext         = {{32{op_b_q[31]}}, op_b_q};
   // POV walks all 32 exponent bits; every other opcode finishes in one cycle
   assign exec_last     = (opc_q != OPC_POV) || (cyc_q == 5'd31);

   assign read_pointer  = rp_q;
   assign res_addr      = res_addr_q;
   assign res_data      = res_data_q;
   assign err           = err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = (count == 6'd0) ? S_FINISH : S_FETCH;
         S_FETCH:  state_d = S_EXEC;
         S_EXEC:   if (exec_last) state_d = S_WRITE;
         S_WRITE:  state_d = (rem_q == 6'd1) ? S_FINISH : S_FETCH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != S_IDLE);
      done   = (state_q == S_FINISH);
      res_we = (state_q == S_WRITE);
   end

   always_comb begin
      acc_step = op_b_q[cyc_q] ? acc_q * base_q : acc_q;
      alu_res  = '0;
      alu_err  = 1'b0;
      case (opc_q)
         OPC_ZERO:  alu_res = '0;
         OPC_PASSA: alu_res = a_ext;
         OPC_PASSB: alu_res = b_ext;
         OPC_ADD:   alu_res = a_ext + b_ext;
         OPC_SUB:   alu_res = a_ext - b_ext;
         OPC_MULT:  alu_res = a_ext * b_ext;
         OPC_DIV:   if (op_b_q == '0) alu_err = 1'b1; else alu_res = a_ext / b_ext;
         OPC_MOD:   if (op_b_q == '0) alu_err = 1'b1; else alu_res = a_ext % b_ext;
         // negative exponent yields 0; the sign bit is the last bit walked
         OPC_POV:   alu_res = op_b_q[31] ? '0 : acc_step;
         default:   alu_err = 1'b1;
      endcase
   end

   always_comb begin
      rp_d       = rp_q;
      rem_d      = rem_q;
      opc_d      = opc_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      cyc_d      = cyc_q;
      acc_d      = acc_q;
      base_d     = base_q;
      res_addr_d = res_addr_q;
      res_data_d = res_data_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rp_d  = first_addr;
               rem_d = count;
               err_d = 1'b0;
            end
         end
         S_FETCH: begin
            opc_d  = instruction_word.opc;
            op_a_d = instruction_word.op_a;
            op_b_d = instruction_word.op_b;
            cyc_d  = '0;
            acc_d  = 64'd1;
            base_d = {{32{instruction_word.op_a[31]}}, instruction_word.op_a};
         end
         S_EXEC: begin
            cyc_d  = cyc_q + 5'd1;
            acc_d  = acc_step;
            base_d = base_q * base_q;
            if (exec_last) begin
               res_addr_d = rp_q;
               res_data_d = alu_res;
               err_d      = err_q | alu_err;
            end
         end
         S_WRITE: begin
            rem_d = rem_q - 6'd1;
            rp_d  = rp_q + 5'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rp_q       <= '0;
         rem_q      <= '0;
         opc_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         cyc_q      <= '0;
         acc_q      <= '0;
         base_q     <= '0;
         res_addr_q <= '0;
         res_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         rp_q       <= rp_d;
         rem_q      <= rem_d;
         opc_q      <= opc_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         cyc_q      <= cyc_d;
         acc_q      <= acc_d;
         base_q     <= base_d;
         res_addr_q <= res_addr_d;
         res_data_q <= res_data_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_instr_executor.sv
// Bench for instr_executor: register file model, queued expected writes/done events,
// negedge monitor that checks every write, done pulse, busy level and output hold.
module tb_instr_executor;
   import instr_pkg::*;

   typedef struct {
      address_t addr;
      longint   data;
      int       cyc;
   } wr_t;

   typedef struct {
      bit err;
      int cyc;
   } dn_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   address_t     first_addr;
   logic [5:0]   count;
   address_t     read_pointer;
   instruction_t instruction_word;
   logic         res_we;
   address_t     res_addr;
   operand_d_t   res_data;
   logic         busy;
   logic         done;
   logic         err;

   instruction_t mem [32];
   wr_t          exp_wr_q[$];
   dn_t          exp_dn_q[$];
   wr_t          seen_q[$];

   int       vecs = 0;
   int       fails = 0;
   int       cyc = 0;
   int       start_cyc = 0;
   int       done_cnt = 0;
   int       last_done_cyc = 0;
   bit       batch_active = 0;
   bit       have_last = 0;
   address_t last_addr;
   longint   last_data;

   instr_executor dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .first_addr       (first_addr),
      .count            (count),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .res_we           (res_we),
      .res_addr         (res_addr),
      .res_data         (res_data),
      .busy             (busy),
      .done             (done),
      .err              (err)
   );

   assign instruction_word = mem[read_pointer];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, longint act, longint exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endfunction

   function automatic void seen_chk(string nm, int idx, address_t a, longint d);
      if (idx >= seen_q.size()) begin
         vecs++;
         fails++;
         $display("FAIL %s: write %0d missing, only %0d seen", nm, idx, seen_q.size());
      end else begin
         chk({nm, "_addr"}, seen_q[idx].addr, a);
         chk({nm, "_data"}, seen_q[idx].data, d);
      end
   endfunction

   function automatic instruction_t mk(opcode_t o, longint a, longint b);
      instruction_t r;
      r.opc    = o;
      r.op_a   = 32'(a);
      r.op_b   = 32'(b);
      r.result = {$urandom, $urandom};
      return r;
   endfunction

   // Reference semantics in plain 64-bit integer arithmetic
   function automatic void ref_exec(input instruction_t ins, output longint r, output bit e);
      longint a, b, base;
      a = longint'(ins.op_a);
      b = longint'(ins.op_b);
      r = 0;
      e = 0;
      case (ins.opc)
         OPC_ZERO:  r = 0;
         OPC_PASSA: r = a;
         OPC_PASSB: r = b;
         OPC_ADD:   r = a + b;
         OPC_SUB:   r = a - b;
         OPC_MULT:  r = a * b;
         OPC_DIV:   if (b == 0) e = 1; else r = a / b;
         OPC_MOD:   if (b == 0) e = 1; else r = a % b;
         OPC_POV: begin
            if (b >= 0) begin
               r    = 1;
               base = a;
               for (longint k = b; k > 0; k = k / 2) begin
                  if (k % 2 == 1) r = r * base;
                  base = base * base;
               end
            end
         end
         default: e = 1;
      endcase
   endfunction

   function automatic operand_t rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'sd0;
         1:       return ($urandom_range(0, 1) == 1) ? 32'sd1 : -32'sd1;
         2:       return 32'sh8000_0000;
         3:       return 32'sh7fff_ffff;
         4:       return 32'($urandom_range(0, 20)) - 32'sd10;
         default: return 32'($urandom);
      endcase
   endfunction

   function automatic instruction_t rnd_ins(bit allow_pov);
      instruction_t r;
      r = mk(OPC_ZERO, 0, 0);
      r.opc  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      if (!allow_pov && r.opc == OPC_POV) r.opc = OPC_SUB;
      r.op_a = rnd_op();
      r.op_b = rnd_op();
      if (r.opc == OPC_POV && $urandom_range(0, 2) != 0) begin
         r.op_a = 32'($urandom_range(0, 12)) - 32'sd6;
         r.op_b = 32'($urandom_range(0, 70));
      end
      return r;
   endfunction

   task automatic run_batch(input address_t fa, input int n, input bit glitch);
      int       t, d0;
      longint   r;
      bit       e, eacc;
      address_t a;
      wr_t      w;
      dn_t      dn;
      t    = 0;
      eacc = 0;
      a    = fa;
      seen_q.delete();
      for (int i = 0; i < n; i++) begin
         ref_exec(mem[a], r, e);
         t += (mem[a].opc == OPC_POV) ? 34 : 3;
         w.addr = a;
         w.data = r;
         w.cyc  = t;
         exp_wr_q.push_back(w);
         eacc |= e;
         a = a + 5'd1;
      end
      dn.err = eacc;
      dn.cyc = t + 1;
      exp_dn_q.push_back(dn);
      d0 = done_cnt;
      @(negedge clk);
      start      = 1'b1;
      first_addr = fa;
      count      = 6'(n);
      @(posedge clk);
      #1;
      start_cyc    = cyc;
      batch_active = 1;
      start        = 1'b0;
      chk("err_cleared_on_start", err, 0);
      if (glitch) begin
         repeat (2) @(negedge clk);
         start      = 1'b1;
         first_addr = fa + 5'd9;
         count      = 6'd3;
         @(negedge clk);
         start = 1'b0;
      end
      for (int k = 0; k < t + 20 && done_cnt == d0; k++) @(posedge clk);
      if (done_cnt == d0) begin
         vecs++;
         fails++;
         $display("FAIL done_timeout: no done within %0d cycles, expected at %0d", t + 20, t + 1);
         exp_wr_q.delete();
         exp_dn_q.delete();
         batch_active = 0;
      end
      chk("writes_pending", exp_wr_q.size(), 0);
   endtask

   always @(negedge clk) begin : monitor
      wr_t w;
      dn_t dn;
      if (!reset_n) begin
         have_last = 0;
      end else begin
         if (batch_active) chk("busy_in_batch", busy, 1);
         if (res_we) begin
            w.addr = res_addr;
            w.data = res_data;
            w.cyc  = cyc - start_cyc + 1;
            seen_q.push_back(w);
            if (exp_wr_q.size() == 0) begin
               vecs++;
               fails++;
               $display("FAIL unexpected_write: addr %0d data %0d, none expected", res_addr, res_data);
            end else begin
               w = exp_wr_q.pop_front();
               chk("wr_addr", res_addr, w.addr);
               chk("wr_data", res_data, w.data);
               chk("wr_cycle", cyc - start_cyc + 1, w.cyc);
            end
            last_addr = res_addr;
            last_data = res_data;
            have_last = 1;
         end else if (have_last) begin
            chk("hold_addr", res_addr, last_addr);
            chk("hold_data", res_data, last_data);
         end
         if (done) begin
            last_done_cyc = cyc - start_cyc + 1;
            if (exp_dn_q.size() == 0) begin
               vecs++;
               fails++;
               $display("FAIL unexpected_done: at cycle %0d, none expected", last_done_cyc);
            end else begin
               dn = exp_dn_q.pop_front();
               chk("done_cycle", last_done_cyc, dn.cyc);
               chk("done_err", err, dn.err);
            end
            batch_active = 0;
            done_cnt++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      address_t fa;
      reset_n    = 1'b0;
      start      = 1'b0;
      first_addr = '0;
      count      = '0;
      for (int i = 0; i < 32; i++) mem[i] = mk(OPC_ZERO, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_res_we", res_we, 0);
      chk("rst_err", err, 0);
      chk("rst_read_pointer", read_pointer, 0);
      chk("rst_res_addr", res_addr, 0);
      chk("rst_res_data", res_data, 0);
      @(posedge clk);
      #2 reset_n = 1'b1;

      mem[0] = mk(OPC_ADD, 5, -7);
      run_batch(5'd0, 1, 0);
      seen_chk("add", 0, 5'd0, -2);
      chk("add_we_cycle", (seen_q.size() > 0) ? seen_q[0].cyc : -1, 3);
      chk("add_done_cycle", last_done_cyc, 4);
      chk("add_err", err, 0);

      mem[31] = mk(OPC_MULT, -65536, 65536);
      mem[0]  = mk(OPC_DIV, 7, 0);
      run_batch(5'd31, 2, 0);
      seen_chk("mult", 0, 5'd31, -64'sd4294967296);
      seen_chk("div0", 1, 5'd0, 0);
      chk("div0_err_sticky", err, 1);
      chk("b2_done_cycle", last_done_cyc, 7);

      mem[7] = mk(OPC_POV, 3, 5);
      run_batch(5'd7, 1, 0);
      seen_chk("pov_3_5", 0, 5'd7, 243);
      chk("pov_we_cycle", (seen_q.size() > 0) ? seen_q[0].cyc : -1, 34);
      mem[8] = mk(OPC_POV, 2, -1);
      run_batch(5'd8, 1, 0);
      seen_chk("pov_neg", 0, 5'd8, 0);
      chk("pov_neg_err", err, 0);
      mem[9] = mk(OPC_POV, 0, 0);
      run_batch(5'd9, 1, 0);
      seen_chk("pov_0_0", 0, 5'd9, 1);

      mem[10] = mk(OPC_MOD, -7, 2);
      mem[11] = mk(OPC_ZERO, 3, 4);
      mem[11].opc = 4'hF;
      run_batch(5'd10, 2, 0);
      seen_chk("mod", 0, 5'd10, -1);
      seen_chk("bad_opc", 1, 5'd11, 0);
      chk("bad_opc_err", err, 1);

      // abort a POV mid-EXEC with err still set from the previous batch
      mem[3] = mk(OPC_POV, 3, 5);
      @(negedge clk);
      start      = 1'b1;
      first_addr = 5'd3;
      count      = 6'd1;
      @(posedge clk);
      #1;
      start        = 1'b0;
      start_cyc    = cyc;
      batch_active = 1;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      #1;
      batch_active = 0;
      chk("abort_busy", busy, 0);
      chk("abort_res_we", res_we, 0);
      chk("abort_done", done, 0);
      chk("abort_err", err, 0);
      chk("abort_read_pointer", read_pointer, 0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b1;
      mem[20] = mk(OPC_SUB, -3, 4);
      run_batch(5'd20, 1, 0);
      seen_chk("after_reset", 0, 5'd20, -7);

      run_batch(5'd17, 0, 0);
      chk("count0_done_cycle", last_done_cyc, 1);
      chk("count0_writes", seen_q.size(), 0);

      mem[12] = mk(OPC_PASSA, -9, 1);
      mem[13] = mk(OPC_PASSB, 1, -11);
      run_batch(5'd12, 2, 1);
      chk("glitch_writes", seen_q.size(), 2);

      for (int i = 0; i < 32; i++) mem[i] = rnd_ins(0);
      run_batch(5'd5, 32, 0);
      chk("full_writes", seen_q.size(), 32);
      chk("full_first_addr", (seen_q.size() == 32) ? seen_q[0].addr : 99, 5);
      chk("full_wrap_addr", (seen_q.size() == 32) ? seen_q[27].addr : 99, 0);
      chk("full_last_addr", (seen_q.size() == 32) ? seen_q[31].addr : 99, 4);

      for (int b = 0; b < 20; b++) begin
         n  = $urandom_range(1, 6);
         fa = 5'($urandom);
         for (int i = 0; i < n; i++) mem[5'(fa + 5'(i))] = rnd_ins(1);
         run_batch(fa, n, $urandom_range(0, 3) == 0);
      end

      repeat (5) @(negedge clk);
      chk("final_wr_queue", exp_wr_q.size(), 0);
      chk("final_done_queue", exp_dn_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule
